// File: rtl/stack_req_arbiter.sv
// Round-robin arbiter sharing one LIFO stack between requesters A and B.
// Optional occupancy counter on the level port is enabled by defining STACK_ARB_LEVEL_EN.
module stack_req_arbiter #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_op,
    input  logic [WIDTH-1:0]      a_wdata,
    output logic                  a_ack,
    input  logic                  b_req,
    input  logic                  b_op,
    input  logic [WIDTH-1:0]      b_wdata,
    output logic                  b_ack,
    output logic                  err,
    output logic [WIDTH-1:0]      rdata,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [WIDTH-1:0]      stk_wdata,
    input  logic [WIDTH-1:0]      stk_top,
    input  logic                  stk_full,
    input  logic                  stk_empty
`ifdef STACK_ARB_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             op_q;
    logic [WIDTH-1:0] wdata_q;
    logic             id_q;
    logic             last_grant;
    logic             err_q;
    logic             grant_b;
    logic             push_ok;
    logic             pop_ok;

    // id/last_grant encoding: 0 = A, 1 = B; on a tie the side not served last wins
    always_comb begin
        state_next = state;
        grant_b    = (a_req && b_req) ? ~last_grant : b_req;
        push_ok    = (state == ISSUE) && op_q && !stk_full;
        pop_ok     = (state == ISSUE) && !op_q && !stk_empty;
        case (state)
            IDLE:    if (a_req || b_req) state_next = ISSUE;
            ISSUE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= 1'b0;
            wdata_q    <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            err_q      <= 1'b0;
            rdata      <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && (a_req || b_req)) begin
                op_q       <= grant_b ? b_op : a_op;
                wdata_q    <= grant_b ? b_wdata : a_wdata;
                id_q       <= grant_b;
                last_grant <= grant_b;
            end
            if (state == ISSUE) begin
                err_q <= !(push_ok || pop_ok);
                if (pop_ok) rdata <= stk_top;
            end
        end
    end

    assign stk_push  = push_ok;
    assign stk_pop   = pop_ok;
    assign stk_wdata = wdata_q;
    assign a_ack     = (state == DONE) && !id_q;
    assign b_ack     = (state == DONE) && id_q;
    assign err       = (state == DONE) && err_q;

`ifdef STACK_ARB_LEVEL_EN
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

    // Saturating occupancy tracker that follows the strobes we issue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= '0;
        end else if (stk_push && level != DEPTH) begin
            level <= level + 1'b1;
        end else if (stk_pop && level != '0) begin
            level <= level - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stack_req_arbiter.sv
// Directed self-checking bench for stack_req_arbiter; level checks only when STACK_ARB_LEVEL_EN is defined.
module tb_stack_req_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_req, a_op, b_req, b_op;
    logic [7:0] a_wdata, b_wdata;
    logic       a_ack, b_ack, err;
    logic [7:0] rdata;
    logic       stk_push, stk_pop;
    logic [7:0] stk_wdata, stk_top;
    logic       stk_full, stk_empty;
`ifdef STACK_ARB_LEVEL_EN
    logic [4:0] level;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    stack_req_arbiter #(.WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_op(a_op), .a_wdata(a_wdata), .a_ack(a_ack),
        .b_req(b_req), .b_op(b_op), .b_wdata(b_wdata), .b_ack(b_ack),
        .err(err), .rdata(rdata),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
        .stk_top(stk_top), .stk_full(stk_full), .stk_empty(stk_empty)
`ifdef STACK_ARB_LEVEL_EN
        , .level(level)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic doReset();
        reset = 1'b1;
        a_req = 1'b0; a_op = 1'b0; a_wdata = 8'h00;
        b_req = 1'b0; b_op = 1'b0; b_wdata = 8'h00;
        stk_top = 8'h00; stk_full = 1'b0; stk_empty = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One request from A (useB=0) or B (useB=1); reports strobes seen and ack timing
    task automatic applyStimulus(input logic useB, input logic op, input logic [7:0] wd,
                                 output int pushCnt, output int popCnt, output logic [7:0] wdSeen,
                                 output logic errSeen, output int ackCycle, output int wrongAck);
        pushCnt = 0; popCnt = 0; wdSeen = 8'h00; errSeen = 1'b0; ackCycle = -1; wrongAck = 0;
        if (useB) begin b_req = 1'b1; b_op = op; b_wdata = wd; end
        else      begin a_req = 1'b1; a_op = op; a_wdata = wd; end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (stk_push) begin pushCnt++; wdSeen = stk_wdata; end
            if (stk_pop) popCnt++;
            if (useB ? a_ack : b_ack) wrongAck++;
            if (useB ? b_ack : a_ack) begin
                errSeen = err; ackCycle = c;
                a_req = 1'b0; b_req = 1'b0;
                break;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk); #1;
    endtask

    int         pc, oc, ac, wa, ackCount, ackBoth;
    logic [7:0] ws;
    logic       es;
    logic [1:0] order [4];
    int         ackAt [4];

    initial begin
        doReset();
        #1;
        checkOutput("reset a_ack", a_ack, 0);
        checkOutput("reset b_ack", b_ack, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset rdata", rdata, 0);
        checkOutput("reset stk_push", stk_push, 0);
        checkOutput("reset stk_pop", stk_pop, 0);
        checkOutput("reset stk_wdata", stk_wdata, 0);

        // A push succeeds
        applyStimulus(1'b0, 1'b1, 8'h5A, pc, oc, ws, es, ac, wa);
        checkOutput("t1 push count", pc, 1);
        checkOutput("t1 stk_wdata", ws, 8'h5A);
        checkOutput("t1 ack cycle", ac, 2);
        checkOutput("t1 err", es, 0);
        checkOutput("t1 wrong ack", wa, 0);

        // A pop succeeds
        stk_top = 8'h5A;
        applyStimulus(1'b0, 1'b0, 8'h00, pc, oc, ws, es, ac, wa);
        checkOutput("t2 pop count", oc, 1);
        checkOutput("t2 push count", pc, 0);
        checkOutput("t2 ack cycle", ac, 2);
        checkOutput("t2 rdata", rdata, 8'h5A);
        checkOutput("t2 err", es, 0);

        // B pop rejected on empty
        stk_empty = 1'b1; stk_top = 8'hC3;
        applyStimulus(1'b1, 1'b0, 8'h00, pc, oc, ws, es, ac, wa);
        checkOutput("t3 pop count", oc, 0);
        checkOutput("t3 ack cycle", ac, 2);
        checkOutput("t3 err", es, 1);
        checkOutput("t3 rdata", rdata, 8'h5A);
        checkOutput("t3 wrong ack", wa, 0);
        checkOutput("t3 err after ack", err, 0);
        stk_empty = 1'b0;

        // A push rejected on full
        stk_full = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h77, pc, oc, ws, es, ac, wa);
        checkOutput("t4 push count", pc, 0);
        checkOutput("t4 ack cycle", ac, 2);
        checkOutput("t4 err", es, 1);
        stk_full = 1'b0;

        // Both held from reset: grants must alternate A,B,A,B
        doReset();
        a_req = 1'b1; a_op = 1'b1; a_wdata = 8'h11;
        b_req = 1'b1; b_op = 1'b1; b_wdata = 8'h22;
        ackCount = 0; ackBoth = 0;
        for (int c = 1; c <= 20 && ackCount < 4; c++) begin
            @(posedge clk); #1;
            if (a_ack && b_ack) ackBoth++;
            if (a_ack || b_ack) begin
                order[ackCount] = {a_ack, b_ack};
                ackAt[ackCount] = c;
                ackCount++;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        checkOutput("t5 ack count", ackCount, 4);
        checkOutput("t5 both acks", ackBoth, 0);
        if (ackCount == 4) begin
            checkOutput("t5 grant0", order[0], 2'b10);
            checkOutput("t5 grant1", order[1], 2'b01);
            checkOutput("t5 grant2", order[2], 2'b10);
            checkOutput("t5 grant3", order[3], 2'b01);
            checkOutput("t5 first ack", ackAt[0], 2);
            checkOutput("t5 spacing", ackAt[3] - ackAt[0], 9);
        end
        @(posedge clk); #1;

        // Reset during ISSUE of a push
        a_req = 1'b1; a_op = 1'b1; a_wdata = 8'h99;
        @(posedge clk); #1;
        checkOutput("t6 push in issue", stk_push, 1);
        reset = 1'b1;
        #1;
        checkOutput("t6 push after reset", stk_push, 0);
        checkOutput("t6 a_ack after reset", a_ack, 0);
        checkOutput("t6 stk_wdata after reset", stk_wdata, 0);
        a_req = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        ackCount = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (a_ack || b_ack || stk_push || stk_pop) ackCount++;
        end
        checkOutput("t6 no late ack", ackCount, 0);

`ifdef STACK_ARB_LEVEL_EN
        doReset();
        #1 checkOutput("lvl reset", level, 0);
        applyStimulus(1'b0, 1'b1, 8'h01, pc, oc, ws, es, ac, wa);
        applyStimulus(1'b1, 1'b1, 8'h02, pc, oc, ws, es, ac, wa);
        applyStimulus(1'b0, 1'b1, 8'h03, pc, oc, ws, es, ac, wa);
        checkOutput("lvl after 3 push", level, 3);
        stk_top = 8'h03;
        applyStimulus(1'b1, 1'b0, 8'h00, pc, oc, ws, es, ac, wa);
        checkOutput("lvl after pop", level, 2);
        checkOutput("lvl rdata", rdata, 8'h03);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
